// File: rtl/mealy_seq_detector.sv
// Serial Mealy detector for a 4-bit pattern (MSB first, overlapping matches), one-hot state exported.
// Optional saturating match counter on port match_cnt when MEALY_MATCH_CNT_EN is defined.
//
//   state | meaning
//   S0    | no prefix of PATTERN matched
//   S1    | last bit equals PATTERN[3]
//   S2    | last two bits equal PATTERN[3:2]
//   S3    | last three bits equal PATTERN[3:1]; y=1 when x equals PATTERN[0]
module mealy_seq_detector #(
    parameter logic [3:0] PATTERN = 4'b1011
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       x,
    output logic       y,
    output logic [3:0] state
`ifdef MEALY_MATCH_CNT_EN
    ,
    output logic [7:0] match_cnt
`endif
);

    typedef enum logic [3:0] {
        S0 = 4'b0001,
        S1 = 4'b0010,
        S2 = 4'b0100,
        S3 = 4'b1000
    } state_t;

    // Longest k' <= 3 such that the bits seen (prefix of length k, then b) end in PATTERN[3:4-k'].
    function automatic int next_len(input int k, input logic b);
        logic [3:0] seq;
        int         len;
        bit         ok;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < k)
                seq[i] = PATTERN[3-i];
            else if (i == k)
                seq[i] = b;
        end
        len = k + 1;
        for (int j = 3; j >= 1; j--) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int t = 0; t < 3; t++) begin
                    if (t < j && seq[len-j+t] != PATTERN[3-t])
                        ok = 1'b0;
                end
                if (ok)
                    return j;
            end
        end
        return 0;
    endfunction

    logic [3:0] next_tbl [4][2];

    for (genvar gk = 0; gk < 4; gk++) begin : g_len
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int NL = next_len(gk, gb[0]);
            assign next_tbl[gk][gb] = 4'(1 << NL);
        end
    end

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge cp) begin
        if (reset)
            state_q <= S0;
        else
            state_q <= state_d;
    end

    // Non-one-hot codes fall into the default arm and recover to S0.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = next_tbl[0][x];
            S1:      state_d = next_tbl[1][x];
            S2:      state_d = next_tbl[2][x];
            S3:      state_d = next_tbl[3][x];
            default: state_d = S0;
        endcase
    end

    assign y     = (state_q == S3) && (x == PATTERN[0]);
    assign state = state_q;

`ifdef MEALY_MATCH_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge cp) begin
        if (reset)
            cnt_q <= '0;
        else if (y && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector: directed scenarios then random bits vs a history-based model.
// Checks match_cnt as well when MEALY_MATCH_CNT_EN is defined.
module tb_mealy_seq_detector;

    localparam logic [3:0] PAT = 4'b1011;

    logic       cp = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       y;
    logic [3:0] state;
`ifdef MEALY_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Model: bits received since the last reset, newest in bit 0.
    logic [3:0] hist = '0;
    int         nb = 0;
    int         m_cnt = 0;
    int         ypulses = 0;

    mealy_seq_detector #(.PATTERN(PAT)) dut (
        .cp(cp),
        .reset(reset),
        .x(x),
        .y(y),
        .state(state)
`ifdef MEALY_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    always #5 cp = ~cp;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_y(input logic b);
        return (nb >= 3) && ({hist[2:0], b} == PAT);
    endfunction

    function automatic logic [3:0] model_state();
        bit ok;
        for (int j = 3; j >= 1; j--) begin
            if (nb >= j) begin
                ok = 1'b1;
                for (int t = 0; t < 3; t++)
                    if (t < j && hist[j-1-t] != PAT[3-t])
                        ok = 1'b0;
                if (ok)
                    return 4'(1 << j);
            end
        end
        return 4'b0001;
    endfunction

    task automatic check_after_edge(input string tag);
        check({tag, "/state"}, {4'h0, state}, {4'h0, model_state()});
`ifdef MEALY_MATCH_CNT_EN
        check({tag, "/cnt"}, match_cnt, 8'(m_cnt));
`endif
    endtask

    task automatic step(input logic b, input string tag);
        logic ey;
        @(negedge cp);
        reset = 1'b0;
        x = b;
        #1;
        ey = model_y(b);
        check({tag, "/y"}, {7'h0, y}, {7'h0, ey});
        @(posedge cp);
        if (ey) begin
            ypulses++;
            if (m_cnt < 255) m_cnt++;
        end
        hist = {hist[2:0], b};
        if (nb < 4) nb++;
        #1;
        check_after_edge(tag);
    endtask

    task automatic rst_cycle(input logic b, input string tag);
        @(negedge cp);
        reset = 1'b1;
        x = b;
        #1;
        check({tag, "/y"}, {7'h0, y}, {7'h0, model_y(b)});
        @(posedge cp);
        hist = '0;
        nb = 0;
        m_cnt = 0;
        #1;
        check_after_edge(tag);
    endtask

    initial begin
        // 1: reset for two edges, then hold with x toggling
        rst_cycle(1'b0, "rst0");
        rst_cycle(1'b0, "rst1");
        for (int i = 0; i < 4; i++) rst_cycle(logic'(i[0]), "rst_hold");
        check("rst/state_abs", {4'h0, state}, 8'h01);

        // 2: single match
        ypulses = 0;
        step(1'b1, "m1"); check("m1/abs", {4'h0, state}, 8'h02);
        step(1'b0, "m2"); check("m2/abs", {4'h0, state}, 8'h04);
        step(1'b1, "m3"); check("m3/abs", {4'h0, state}, 8'h08);
        step(1'b1, "m4"); check("m4/abs", {4'h0, state}, 8'h02);
        check("m/pulses", 8'(ypulses), 8'd1);

        // 3: overlap
        rst_cycle(1'b0, "ov_rst");
        ypulses = 0;
        foreach (PAT[i]) step(PAT[i], "ov");
        step(1'b0, "ov"); step(1'b1, "ov"); step(1'b1, "ov");
        check("ov/pulses", 8'(ypulses), 8'd2);
`ifdef MEALY_MATCH_CNT_EN
        check("ov/cnt_abs", match_cnt, 8'd2);
`endif

        // 4: near miss 1,0,1,0,1,1
        rst_cycle(1'b0, "nm_rst");
        ypulses = 0;
        step(1'b1, "nm"); step(1'b0, "nm"); step(1'b1, "nm");
        step(1'b0, "nm"); check("nm/s2", {4'h0, state}, 8'h04);
        step(1'b1, "nm"); step(1'b1, "nm");
        check("nm/pulses", 8'(ypulses), 8'd1);

        // 5: reset mid-sequence
        rst_cycle(1'b0, "mr_rst");
        step(1'b1, "mr"); step(1'b0, "mr"); step(1'b1, "mr");
        rst_cycle(1'b0, "mr_mid");
        ypulses = 0;
        step(1'b1, "mr_after");
        check("mr/pulses", 8'(ypulses), 8'd0);

        // 6: combinational y in S3, then illegal-state recovery
        rst_cycle(1'b0, "cb_rst");
        step(1'b1, "cb"); step(1'b0, "cb"); step(1'b1, "cb");
        @(negedge cp);
        x = 1'b0; #1; check("cb/y0", {7'h0, y}, 8'h00);
        x = 1'b1; #1; check("cb/y1", {7'h0, y}, 8'h01);
        x = 1'b0; #1; check("cb/y2", {7'h0, y}, 8'h00);
        @(posedge cp);
        hist = {hist[2:0], 1'b0};
        nb = 4;
        #1;
        check_after_edge("cb_edge");

        @(negedge cp);
        force dut.state_q = 4'b0000;
        x = 1'b1;
        #1;
        check("ill/y", {7'h0, y}, 8'h00);
        check("ill/state", {4'h0, state}, 8'h00);
        release dut.state_q;
        @(posedge cp);
        hist = '0;
        nb = 0;
        #1;
        check("ill/recover", {4'h0, state}, 8'h01);
`ifdef MEALY_MATCH_CNT_EN
        check("ill/cnt", match_cnt, 8'(m_cnt));
`endif

        // Random stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0)
                rst_cycle(logic'($urandom_range(0, 1)), "rnd_rst");
            else
                step(logic'($urandom_range(0, 1)), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule
